// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO pop reader: FSM encoding and output buffer depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_FLUSH} rd_state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry in-order buffer between the FIFO pop path and the output stream.
// Entry 0 is always the head, so rdata never needs a mux.
module reader_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            wr,
  input  logic [bits-1:0] wdata,
  input  logic            rd,
  output logic [bits-1:0] rdata,
  output logic [1:0]      cnt
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [bits-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]      cnt_q, cnt_d;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else begin
      unique case ({wr, rd})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            ent0_d = wdata;
            cnt_d  = 2'd1;
          end else if (cnt_q < FULL) begin
            ent1_d = wdata;
            cnt_d  = cnt_q + 2'd1;
          end
        end
        2'b01: begin
          if (cnt_q != 2'd0) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
          end
        end
        2'b11: begin
          // Accept and refill together: occupancy is unchanged, head advances.
          if (cnt_q == 2'd1) begin
            ent0_d = wdata;
          end else if (cnt_q == FULL) begin
            ent0_d = ent1_q;
            ent1_d = wdata;
          end else begin
            ent0_d = wdata;
            cnt_d  = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata = ent0_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/fifo_pop_reader.sv
// Pops words from a fifo_flops read port into a 2-entry buffer and streams them out
// as valid/ready; a flush discards the buffer and drains the FIFO.
module fifo_pop_reader
  import fifo_rd_pkg::*;
#(
  parameter int bits  = 16,
  parameter int cnt_w = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  output logic             flush_done,
  input  logic [bits-1:0]  fifo_dout,
  input  logic             fifo_pndng,
  output logic             fifo_pop,
  output logic [bits-1:0]  m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [cnt_w-1:0] word_count
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  rd_state_t        state_q;
  logic             flush_done_q;
  logic [cnt_w-1:0] word_count_q;
  logic [1:0]       buf_cnt;
  logic             accept, flush_go, buf_wr;

  assign m_valid  = (buf_cnt != 2'd0);
  assign accept   = m_valid && m_ready;
  assign flush_go = flush && (state_q != RD_FLUSH);
  assign buf_wr   = fifo_pop && (state_q == RD_RUN);

  // Pop decision looks only at registered occupancy, keeping m_ready off this path.
  always_comb begin
    fifo_pop = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RD_RUN:   fifo_pop = enable && fifo_pndng && (buf_cnt < FULL);
        RD_FLUSH: fifo_pop = fifo_pndng;
        default:  fifo_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RD_IDLE;
      flush_done_q <= 1'b0;
      word_count_q <= '0;
    end else begin
      flush_done_q <= 1'b0;
      if (accept) word_count_q <= word_count_q + cnt_w'(1);
      unique case (state_q)
        RD_IDLE: begin
          if (flush)       state_q <= RD_FLUSH;
          else if (enable) state_q <= RD_RUN;
        end
        RD_RUN: begin
          if (flush)        state_q <= RD_FLUSH;
          else if (!enable) state_q <= RD_IDLE;
        end
        RD_FLUSH: begin
          if (!fifo_pndng) begin
            flush_done_q <= 1'b1;
            state_q      <= enable ? RD_RUN : RD_IDLE;
          end
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  reader_skid_buf #(.bits(bits)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_go),
    .wr    (buf_wr),
    .wdata (fifo_dout),
    .rd    (accept),
    .rdata (m_data),
    .cnt   (buf_cnt)
  );

  assign flush_done = flush_done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_pop_reader.sv
// Bench for fifo_pop_reader: queue-based FIFO and stream model, directed scenarios plus random traffic.
module tb_fifo_pop_reader;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1, enable = 1'b0, flush = 1'b0, m_ready = 1'b0;
  logic          fifo_pndng = 1'b0;
  logic [W-1:0]  fifo_dout = '0;
  logic          flush_done, fifo_pop, m_valid;
  logic [W-1:0]  m_data;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  fifo_pop_reader #(.bits(W), .cnt_w(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush      (flush),
    .flush_done (flush_done),
    .fifo_dout  (fifo_dout),
    .fifo_pndng (fifo_pndng),
    .fifo_pop   (fifo_pop),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .word_count (word_count)
  );

  int n_vec = 0, n_err = 0;
  logic [W-1:0] fq[$], bq[$], src[$], outq[$];
  logic [W-1:0] next_word = 1;
  int  mode = 0;  // 0 idle, 1 run, 2 flush
  int  cnt  = 0;
  bit  fd_exp = 0, chk_en = 0, p;
  int  pops = 0, fds = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_pop();
    if (rst || fq.size() == 0) return 1'b0;
    if (mode == 1) return enable && (bq.size() < 2);
    return mode == 2;
  endfunction

  // One clock: check outputs mid-cycle, advance the model, cross the edge.
  task automatic cyc();
    bit acc, push;
    #1;
    p = exp_pop();
    if (chk_en) begin
      chk("m_valid", m_valid, bq.size() != 0);
      if (bq.size() != 0) chk("m_data", m_data, bq[0]);
      chk("fifo_pop", fifo_pop, p);
      chk("word_count", word_count, cnt);
      chk("flush_done", flush_done, fd_exp);
    end
    if (fifo_pop) pops++;
    if (flush_done) fds++;
    if (m_valid && m_ready) outq.push_back(m_data);
    push = (src.size() != 0) && (fq.size() < 8);
    if (rst) begin
      mode = 0; bq.delete(); cnt = 0; fd_exp = 0;
    end else begin
      acc = (bq.size() != 0) && m_ready;
      fd_exp = 0;
      if (acc) begin cnt = (cnt + 1) % (1 << CW); void'(bq.pop_front()); end
      if (mode != 2) begin
        if (flush) begin bq.delete(); mode = 2; end
        else begin
          if (p) bq.push_back(fq[0]);
          mode = enable ? 1 : 0;
        end
      end else if (fq.size() == 0) begin
        fd_exp = 1; mode = enable ? 1 : 0;
      end
    end
    if (p) void'(fq.pop_front());
    if (push) fq.push_back(src.pop_front());
    @(posedge clk);
    #1;
    fifo_pndng = fq.size() != 0;
    fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    @(negedge clk);
    chk_en = 1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic push_words(input int n);
    repeat (n) begin src.push_back(next_word); next_word++; end
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; enable = 0; m_ready = 0;
    src.delete(); fq.delete(); outq.delete();
    fifo_pndng = 0; next_word = 1;
    run(2);
    rst = 0;
  endtask

  initial begin
    // Power-up reset; the second cycle checks reset values against the model.
    do_reset();
    chk("rst_m_data", m_data, 0);

    // 1: 8 words streamed with m_ready held high
    enable = 1; m_ready = 1; push_words(8); run(14);
    chk("s1_count", word_count, 8);
    chk("s1_len", outq.size(), 8);
    for (int i = 0; i < 8 && i < outq.size(); i++) chk("s1_order", outq[i], i + 1);

    // 2: full FIFO, sink stalled for 20 clocks
    do_reset();
    push_words(8); run(9);
    enable = 1; pops = 0; run(20);
    chk("s2_pops", pops, 2);
    chk("s2_head", m_data, 16'h0001);
    m_ready = 1; run(14);
    chk("s2_len", outq.size(), 8);
    for (int i = 0; i < 8 && i < outq.size(); i++) chk("s2_order", outq[i], i + 1);
    chk("s2_count", word_count, 8);

    // 3: flush with 2 buffered and 5 queued, then flush of an empty FIFO
    do_reset();
    push_words(7); run(8);
    enable = 1; run(4);
    flush = 1; pops = 0; fds = 0; cyc(); flush = 0;
    chk("s3_mvalid", m_valid, 0);
    run(10);
    chk("s3_pops", pops, 5);
    chk("s3_fd", fds, 1);
    chk("s3_count", word_count, 0);
    flush = 1; fds = 0; cyc(); flush = 0; cyc();
    chk("s3_empty_fd", flush_done, 1);
    run(2);
    chk("s3_empty_fds", fds, 1);

    // 4: enable dropped mid-stream with random backpressure
    do_reset();
    enable = 1; m_ready = 1; push_words(12); run(5);
    enable = 0; pops = 0; run(6);
    chk("s4_nopop", pops, 0);
    enable = 1;
    for (int i = 0; i < 20; i++) begin m_ready = 1'($urandom_range(0, 1)); cyc(); end
    m_ready = 1; run(12);
    chk("s4_len", outq.size(), 12);
    for (int i = 0; i < 12 && i < outq.size(); i++) chk("s4_order", outq[i], i + 1);
    chk("s4_count", word_count, 12);

    // 5: counter wrap on the 4-bit build
    do_reset();
    enable = 1; m_ready = 1; push_words(17); run(30);
    chk("s5_wrap", word_count, 1);

    // 6: reset mid-stream with flush asserted
    do_reset();
    enable = 1; m_ready = 1; push_words(10); run(4);
    rst = 1; flush = 1; cyc(); rst = 0; flush = 0;
    chk("s6_mvalid", m_valid, 0);
    chk("s6_count", word_count, 0);
    chk("s6_fd", flush_done, 0);
    chk("s6_mdata", m_data, 0);
    chk("s6_pop", fifo_pop, 0);
    run(15);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      enable  = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) != 0 && src.size() < 4) begin
        src.push_back(W'($urandom));
      end
      cyc();
    end
    rst = 0; flush = 0; run(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
